// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - op codes, ALU task codes and state encoding for the multibyte sequencer
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    localparam logic [3:0] TASK_PASS = 4'h0;
    localparam logic [3:0] TASK_ADC  = 4'h1;
    localparam logic [3:0] TASK_ADD  = 4'h2;
    localparam logic [3:0] TASK_AND  = 4'h3;
    localparam logic [3:0] TASK_NOT  = 4'h5;
    localparam logic [3:0] TASK_OR   = 4'h6;
    localparam logic [3:0] TASK_SBC  = 4'h7;
    localparam logic [3:0] TASK_SUB  = 4'h8;
    localparam logic [3:0] TASK_XOR  = 4'h9;
    localparam logic [3:0] TASK_RLC  = 4'hA;
    localparam logic [3:0] TASK_RRC  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // First byte of ADD/SUB uses the carry-less task; later bytes chain.
    function automatic logic [3:0] alu_task(input op_e op, input logic first);
        case (op)
            OP_ADD:  alu_task = first ? TASK_ADD : TASK_ADC;
            OP_SUB:  alu_task = first ? TASK_SUB : TASK_SBC;
            OP_AND:  alu_task = TASK_AND;
            OP_OR:   alu_task = TASK_OR;
            OP_XOR:  alu_task = TASK_XOR;
            OP_NOT:  alu_task = TASK_NOT;
            OP_SHL:  alu_task = TASK_RLC;
            default: alu_task = TASK_RRC;
        endcase
    endfunction

endpackage

// File: rtl/cpu_byte_bank.sv
// rtl/cpu_byte_bank.sv - N_BYTES x 8 register bank, sync write, clear on reset, comb read
module cpu_byte_bank #(
    parameter int N_BYTES = 4,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem_q [N_BYTES];
    logic [7:0] mem_d [N_BYTES];

    // Out-of-range addresses match no entry: writes drop, reads return 0.
    always_comb begin
        mem_d   = mem_q;
        rd_data = 8'h00;
        for (int i = 0; i < N_BYTES; i++) begin
            if (wr_en && (32'(wr_addr) == i)) mem_d[i] = wr_data;
            if (32'(rd_addr) == i) rd_data = mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BYTES; i++) mem_q[i] <= 8'h00;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/cpu_multibyte_seq.sv
// rtl/cpu_multibyte_seq.sv - byte-serial N-byte sequencer driving an external 8-bit ALU
module cpu_multibyte_seq
    import cpu_seq_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int IDX_W   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_Wr,
    input  logic             Load_Sel,
    input  logic [IDX_W-1:0] Load_Addr,
    input  logic [7:0]       Load_Data,
    input  logic             Start,
    input  logic [2:0]       Op,
    output logic             Busy,
    output logic             Done,
    output logic             Carry_Flag,
    output logic             Zero_Flag,
    input  logic [IDX_W-1:0] Res_Addr,
    output logic [7:0]       Res_Data,
    output logic [7:0]       Alu_A,
    output logic [7:0]       Alu_B,
    output logic [3:0]       Alu_Task,
    output logic             Alu_Carry_In,
    output logic             Alu_Zero_In,
    input  logic [7:0]       Alu_Y,
    input  logic             Alu_Carry
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cflag_q, cflag_d;
    logic             zflag_q, zflag_d;
    logic             shadow_valid_q, shadow_valid_d;
    logic             shadow_sel_q, shadow_sel_d;
    logic [IDX_W-1:0] shadow_addr_q, shadow_addr_d;
    logic [7:0]       shadow_data_q, shadow_data_d;

    logic             run;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] op_rd_addr;
    logic [7:0]       a_rd, b_rd, a_byte, b_byte;
    logic             idle_wr;

    assign run        = (state_q == S_RUN);
    assign idx        = (op_q == OP_SHR) ? (LAST - cnt_q) : cnt_q;
    assign op_rd_addr = (state_q == S_IDLE) ? Load_Addr : idx;
    assign idle_wr    = Load_Wr && (state_q == S_IDLE);

    cpu_byte_bank #(.N_BYTES(N_BYTES), .IDX_W(IDX_W)) u_bank_a (
        .clk(Clk), .reset(Reset), .wr_en(idle_wr && !Load_Sel), .wr_addr(Load_Addr),
        .wr_data(Load_Data), .rd_addr(op_rd_addr), .rd_data(a_rd)
    );
    cpu_byte_bank #(.N_BYTES(N_BYTES), .IDX_W(IDX_W)) u_bank_b (
        .clk(Clk), .reset(Reset), .wr_en(idle_wr && Load_Sel), .wr_addr(Load_Addr),
        .wr_data(Load_Data), .rd_addr(op_rd_addr), .rd_data(b_rd)
    );
    cpu_byte_bank #(.N_BYTES(N_BYTES), .IDX_W(IDX_W)) u_bank_res (
        .clk(Clk), .reset(Reset), .wr_en(run), .wr_addr(idx),
        .wr_data(Alu_Y), .rd_addr(Res_Addr), .rd_data(Res_Data)
    );

    // A write landing on the Start edge must not affect this run: substitute the pre-write byte.
    assign a_byte = (shadow_valid_q && !shadow_sel_q && shadow_addr_q == idx) ? shadow_data_q : a_rd;
    assign b_byte = (shadow_valid_q &&  shadow_sel_q && shadow_addr_q == idx) ? shadow_data_q : b_rd;

    assign Alu_A        = run ? a_byte : 8'h00;
    assign Alu_B        = run ? b_byte : 8'h00;
    assign Alu_Task     = run ? alu_task(op_q, cnt_q == '0) : TASK_PASS;
    assign Alu_Carry_In = run ? carry_q : 1'b0;
    assign Alu_Zero_In  = 1'b0;

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Carry_Flag = cflag_q;
    assign Zero_Flag  = zflag_q;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        carry_d        = carry_q;
        zacc_d         = zacc_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        cflag_d        = cflag_q;
        zflag_d        = zflag_q;
        shadow_valid_d = shadow_valid_q;
        shadow_sel_d   = shadow_sel_q;
        shadow_addr_d  = shadow_addr_q;
        shadow_data_d  = shadow_data_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d        = S_RUN;
                    op_d           = op_e'(Op);
                    cnt_d          = '0;
                    carry_d        = 1'b0;
                    zacc_d         = 1'b1;
                    busy_d         = 1'b1;
                    shadow_valid_d = Load_Wr;
                    shadow_sel_d   = Load_Sel;
                    shadow_addr_d  = Load_Addr;
                    shadow_data_d  = Load_Sel ? b_rd : a_rd;
                end
            end
            S_RUN: begin
                // Carry register holds what the next byte's Carry_In needs (borrow for SUB).
                case (op_q)
                    OP_ADD, OP_SHL, OP_SHR: carry_d = Alu_Carry;
                    OP_SUB:                 carry_d = ~Alu_Carry;
                    default:                carry_d = 1'b0;
                endcase
                zacc_d = zacc_q & (Alu_Y == 8'h00);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                state_d        = S_IDLE;
                busy_d         = 1'b0;
                done_d         = 1'b1;
                cflag_d        = carry_q;
                zflag_d        = zacc_q;
                shadow_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            op_q           <= OP_ADD;
            cnt_q          <= '0;
            carry_q        <= 1'b0;
            zacc_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cflag_q        <= 1'b0;
            zflag_q        <= 1'b0;
            shadow_valid_q <= 1'b0;
            shadow_sel_q   <= 1'b0;
            shadow_addr_q  <= '0;
            shadow_data_q  <= 8'h00;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            carry_q        <= carry_d;
            zacc_q         <= zacc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cflag_q        <= cflag_d;
            zflag_q        <= zflag_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_sel_q   <= shadow_sel_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_data_q  <= shadow_data_d;
        end
    end

endmodule
